rv_dmem_arbiter: RTL

- Parametrised N-channel data-memory front end for multi-hart overlay builds; replaces the single-hart direct dmem connection.
- Arbitrates per-hart dmem requests round-robin onto one registered memory request port.
- Tracks outstanding requests in an in-order ID FIFO and routes each memory response back to the issuing hart.
- Sits between the per-hart dpath memory stages and the shared dmem.

---
 rtl/rv_dmem_arbiter_if.sv | 56 +++++
 rtl/rv_dmem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rv_dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// rv_dmem_arbiter_if
// Bundles the per-hart request/response channels and the shared dmem port
// seen by rv_dmem_arbiter.
//   slave  : arbiter view (takes hart requests, drives memory requests)
//   master : environment view (harts plus shared memory)
// Signals:
//   ch_req_valid/ready        per-channel request handshake (NUM_CH bits)
//   ch_req_fcn/typ/addr/wdata packed per-channel request fields
//   ch_resp_valid/rdata       one-hot response strobe, shared response data
//   dmem_valid/ready          shared memory request handshake
//   dmem_fcn/typ/addr/data_i  registered memory request fields
//   dmem_resp_valid/data_o    memory response strobe and read data
//   busy, err_spurious        status
// -----------------------------------------------------------------------------
interface rv_dmem_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int FCN_W  = 1,
   parameter int TYP_W  = 3
);
   logic [NUM_CH-1:0]        ch_req_valid;
   logic [NUM_CH-1:0]        ch_req_ready;
   logic [NUM_CH*FCN_W-1:0]  ch_req_fcn;
   logic [NUM_CH*TYP_W-1:0]  ch_req_typ;
   logic [NUM_CH*DATA_W-1:0] ch_req_addr;
   logic [NUM_CH*DATA_W-1:0] ch_req_wdata;
   logic [NUM_CH-1:0]        ch_resp_valid;
   logic [DATA_W-1:0]        ch_resp_rdata;
   logic                     dmem_valid;
   logic                     dmem_ready;
   logic [FCN_W-1:0]         dmem_fcn;
   logic [TYP_W-1:0]         dmem_typ;
   logic [DATA_W-1:0]        dmem_addr;
   logic [DATA_W-1:0]        dmem_data_i;
   logic                     dmem_resp_valid;
   logic [DATA_W-1:0]        dmem_data_o;
   logic                     busy;
   logic                     err_spurious;

   modport slave (
      input  ch_req_valid, ch_req_fcn, ch_req_typ, ch_req_addr, ch_req_wdata,
      input  dmem_ready, dmem_resp_valid, dmem_data_o,
      output ch_req_ready, ch_resp_valid, ch_resp_rdata,
      output dmem_valid, dmem_fcn, dmem_typ, dmem_addr, dmem_data_i,
      output busy, err_spurious
   );

   modport master (
      output ch_req_valid, ch_req_fcn, ch_req_typ, ch_req_addr, ch_req_wdata,
      output dmem_ready, dmem_resp_valid, dmem_data_o,
      input  ch_req_ready, ch_resp_valid, ch_resp_rdata,
      input  dmem_valid, dmem_fcn, dmem_typ, dmem_addr, dmem_data_i,
      input  busy, err_spurious
   );
endinterface

// File: rtl/rv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// rv_dmem_arbiter
// Round-robin N-channel front end onto one registered dmem request port.
// Accepted channel IDs are queued in order so every memory response is routed
// back to the hart that issued the matching request.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  rv_dmem_arbiter_if.slave (hart channels, dmem port, status)
// -----------------------------------------------------------------------------
module rv_dmem_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 32,
   parameter int FCN_W     = 1,
   parameter int TYP_W     = 3,
   parameter int MAX_OUTST = 4
) (
   input logic              clk,
   input logic              rst,
   rv_dmem_arbiter_if.slave bus
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int ID_W  = $clog2(MAX_OUTST);
   localparam int CNT_W = ID_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

   // registered state
   logic [CH_W-1:0]   r_rr_ptr;
   logic              r_dmem_valid;
   logic [FCN_W-1:0]  r_dmem_fcn;
   logic [TYP_W-1:0]  r_dmem_typ;
   logic [DATA_W-1:0] r_dmem_addr;
   logic [DATA_W-1:0] r_dmem_wdata;
   logic [CH_W-1:0]   r_id_fifo [MAX_OUTST];
   logic [ID_W-1:0]   r_wr_ptr;
   logic [ID_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [NUM_CH-1:0] r_resp_valid;
   logic [DATA_W-1:0] r_resp_rdata;
   logic              r_err_spurious;

   // combinational
   logic              w_found;
   logic [CH_W-1:0]   w_winner;
   logic [CH_W:0]     w_scan;
   logic              w_can_accept;
   logic              w_accept;
   logic              w_resp_hit;
   logic [NUM_CH-1:0] w_ready;
   logic [FCN_W-1:0]  w_sel_fcn;
   logic [TYP_W-1:0]  w_sel_typ;
   logic [DATA_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   // Round-robin search starting at r_rr_ptr. Ready only looks at valid bits,
   // slot availability and the outstanding count, never at request fields.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so
      // no path leaves it unassigned, which would infer a latch.
      w_found  = 1'b0;
      w_winner = '0;
      w_scan   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_scan = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
         if (w_scan >= NUM_CH_L) w_scan = w_scan - NUM_CH_L;
         if (!w_found && bus.ch_req_valid[w_scan[CH_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_scan[CH_W-1:0];
         end
      end

      // No pop bypass: a response in this cycle does not free a slot until next.
      w_can_accept = (!r_dmem_valid || bus.dmem_ready) && (r_count < CNT_MAX) && !rst;
      w_accept     = w_found && w_can_accept;
      w_ready      = '0;
      if (w_found) w_ready[w_winner] = w_can_accept;

      w_sel_fcn   = '0;
      w_sel_typ   = '0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_winner == CH_W'(k)) begin
            w_sel_fcn   = bus.ch_req_fcn[k*FCN_W +: FCN_W];
            w_sel_typ   = bus.ch_req_typ[k*TYP_W +: TYP_W];
            w_sel_addr  = bus.ch_req_addr[k*DATA_W +: DATA_W];
            w_sel_wdata = bus.ch_req_wdata[k*DATA_W +: DATA_W];
         end
      end

      w_resp_hit = bus.dmem_resp_valid && (r_count != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_rr_ptr       <= '0;
         r_dmem_valid   <= 1'b0;
         r_dmem_fcn     <= '0;
         r_dmem_typ     <= '0;
         r_dmem_addr    <= '0;
         r_dmem_wdata   <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_resp_valid   <= '0;
         r_resp_rdata   <= '0;
         r_err_spurious <= 1'b0;
      end else begin
         // Request port: load on accept, otherwise retire when memory takes it.
         if (w_accept) begin
            r_dmem_valid <= 1'b1;
            r_dmem_fcn   <= w_sel_fcn;
            r_dmem_typ   <= w_sel_typ;
            r_dmem_addr  <= w_sel_addr;
            r_dmem_wdata <= w_sel_wdata;
            r_rr_ptr     <= (w_winner == LAST_CH) ? '0 : w_winner + CH_W'(1);
            r_wr_ptr     <= r_wr_ptr + ID_W'(1);
         end else if (bus.dmem_ready) begin
            r_dmem_valid <= 1'b0;
         end

         // Response routing: strobe the channel at the FIFO head for one cycle.
         r_resp_valid <= '0;
         if (w_resp_hit) begin
            r_resp_valid[r_id_fifo[r_rd_ptr]] <= 1'b1;
            r_resp_rdata <= bus.dmem_data_o;
            r_rd_ptr     <= r_rd_ptr + ID_W'(1);
         end else if (bus.dmem_resp_valid) begin
            r_err_spurious <= 1'b1;
         end

         case ({w_accept, w_resp_hit})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the ID storage has no reset; r_count and the pointers define which
   // entries are live, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (w_accept) r_id_fifo[r_wr_ptr] <= w_winner;
   end

   assign bus.ch_req_ready  = w_ready;
   assign bus.ch_resp_valid = r_resp_valid;
   assign bus.ch_resp_rdata = r_resp_rdata;
   assign bus.dmem_valid    = r_dmem_valid;
   assign bus.dmem_fcn      = r_dmem_fcn;
   assign bus.dmem_typ      = r_dmem_typ;
   assign bus.dmem_addr     = r_dmem_addr;
   assign bus.dmem_data_i   = r_dmem_wdata;
   assign bus.busy          = (r_count != '0) || r_dmem_valid;
   assign bus.err_spurious  = r_err_spurious;
endmodule
